// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and load data into the register file
// with zero latency. A load whose data is not yet valid stalls upstream until
// it arrives. The most recent retired writes are kept in a small history so
// that earlier stages can forward from them.
module writeback_unit #(
    parameter int                 DATA_W     = 16,
    parameter int                 TGT_W      = 3,
    parameter int                 OPC_W      = 3,
    parameter int                 HIST_DEPTH = 2,
    parameter logic [OPC_W-1:0]   OPC_LOAD   = 3'b101,
    parameter logic [OPC_W-1:0]   OPC_STORE  = 3'b100,
    parameter logic [OPC_W-1:0]   OPC_BRANCH = 3'b110
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         halt,
    input  logic                         bubble_in,
    input  logic [TGT_W-1:0]             tgt_in,
    input  logic [OPC_W-1:0]             opcode_in,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic [DATA_W-1:0]            mem_result,
    input  logic                         mem_valid,
    output logic                         stall_out,
    output logic                         we,
    output logic [TGT_W-1:0]             wr_tgt,
    output logic [DATA_W-1:0]            wr_data,
    output logic [HIST_DEPTH-1:0]        hist_valid,
    output logic [HIST_DEPTH*TGT_W-1:0]  hist_tgt,
    output logic [HIST_DEPTH*DATA_W-1:0] hist_data
);

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TGT_W-1:0]      r_tgt;
    logic [TGT_W-1:0]      w_tgt_nxt;
    logic                  r_hv   [HIST_DEPTH];
    logic [TGT_W-1:0]      r_ht   [HIST_DEPTH];
    logic [DATA_W-1:0]     r_hd   [HIST_DEPTH];

    logic                  w_writing;
    logic                  w_is_load;
    logic                  w_we;
    logic                  w_stall;
    logic [TGT_W-1:0]      w_wr_tgt;
    logic [DATA_W-1:0]     w_wr_data;

    // A slot writes only when occupied, targets a real register and is not a store/branch.
    assign w_writing = !bubble_in && (tgt_in != '0) &&
                       (opcode_in != OPC_STORE) && (opcode_in != OPC_BRANCH);
    assign w_is_load = (opcode_in == OPC_LOAD);

    // State and latched load target; halt freezes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tgt   <= '0;
        end else if (!halt) begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Next-state and write-port decode.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_we        = 1'b0;
        w_stall     = 1'b0;
        w_wr_tgt    = '0;
        w_wr_data   = '0;
        case (r_state)
            IDLE: begin
                if (w_writing) begin
                    if (!w_is_load) begin
                        w_we      = 1'b1;
                        w_wr_tgt  = tgt_in;
                        w_wr_data = alu_result;
                    end else if (mem_valid) begin
                        w_we      = 1'b1;
                        w_wr_tgt  = tgt_in;
                        w_wr_data = mem_result;
                    end else begin
                        // Load data not back yet: hold upstream and remember where it goes.
                        w_stall     = 1'b1;
                        w_state_nxt = WAIT_MEM;
                        w_tgt_nxt   = tgt_in;
                    end
                end
            end
            WAIT_MEM: begin
                w_stall = 1'b1;
                if (mem_valid && !halt) begin
                    w_we        = 1'b1;
                    w_stall     = 1'b0;
                    w_wr_tgt    = r_tgt;
                    w_wr_data   = mem_result;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Halt blocks the write; the address/data lines drop to zero with it.
        if (halt) begin
            w_we      = 1'b0;
            w_wr_tgt  = '0;
            w_wr_data = '0;
        end
        // Reset overrides every output while held.
        if (!rst_n) begin
            w_we      = 1'b0;
            w_stall   = 1'b0;
            w_wr_tgt  = '0;
            w_wr_data = '0;
        end
    end

    assign we        = w_we;
    assign stall_out = w_stall;
    assign wr_tgt    = w_wr_tgt;
    assign wr_data   = w_wr_data;

    // Retired-write history: shift in on every write, entry 0 newest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hv[i] <= 1'b0;
                r_ht[i] <= '0;
                r_hd[i] <= '0;
            end
        end else if (w_we) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                r_hv[i] <= r_hv[i-1];
                r_ht[i] <= r_ht[i-1];
                r_hd[i] <= r_hd[i-1];
            end
            r_hv[0] <= 1'b1;
            r_ht[0] <= w_wr_tgt;
            r_hd[0] <= w_wr_data;
        end
    end

    // Flatten the history into packed output vectors.
    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_valid[i]                = r_hv[i];
            hist_tgt[i*TGT_W +: TGT_W]   = r_ht[i];
            hist_data[i*DATA_W +: DATA_W] = r_hd[i];
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with default parameters (DATA_W=16,
// TGT_W=3, HIST_DEPTH=2). Inputs change just after a rising edge; the
// combinational write port is sampled mid-cycle and history just after the edge.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        bubble_in;
    logic [2:0]  tgt_in;
    logic [2:0]  opcode_in;
    logic [15:0] alu_result;
    logic [15:0] mem_result;
    logic        mem_valid;
    logic        stall_out;
    logic        we;
    logic [2:0]  wr_tgt;
    logic [15:0] wr_data;
    logic [1:0]  hist_valid;
    logic [5:0]  hist_tgt;
    logic [31:0] hist_data;

    int total;
    int bad;

    writeback_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt       (halt),
        .bubble_in  (bubble_in),
        .tgt_in     (tgt_in),
        .opcode_in  (opcode_in),
        .alu_result (alu_result),
        .mem_result (mem_result),
        .mem_valid  (mem_valid),
        .stall_out  (stall_out),
        .we         (we),
        .wr_tgt     (wr_tgt),
        .wr_data    (wr_data),
        .hist_valid (hist_valid),
        .hist_tgt   (hist_tgt),
        .hist_data  (hist_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input logic [2:0] t, input logic [2:0] op,
                         input logic [15:0] alu, input logic mv, input logic [15:0] mr);
        bubble_in  = b;
        tgt_in     = t;
        opcode_in  = op;
        alu_result = alu;
        mem_valid  = mv;
        mem_result = mr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        halt  = 1'b0;
        drive(1'b0, 3'd3, 3'b000, 16'h5555, 1'b0, 16'h0);
        chk("rst_we", we, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_hv", hist_valid, 2'b00);
        chk("rst_ht", hist_tgt, 6'd0);
        chk("rst_hd", hist_data, 32'd0);
        tick();
        chk("rst_hold_hv", hist_valid, 2'b00);
        rst_n = 1'b1;

        // ALU write to r3
        drive(1'b0, 3'd3, 3'b000, 16'h1234, 1'b0, 16'h0);
        chk("alu_we", we, 1'b1);
        chk("alu_tgt", wr_tgt, 3'd3);
        chk("alu_data", wr_data, 16'h1234);
        chk("alu_stall", stall_out, 1'b0);
        tick();
        chk("alu_hv", hist_valid, 2'b01);
        chk("alu_ht", hist_tgt, 6'd3);
        chk("alu_hd", hist_data, 32'h0000_1234);

        // Non-writing slots
        drive(1'b0, 3'd4, 3'b100, 16'hAAAA, 1'b0, 16'h0);
        chk("store_we", we, 1'b0);
        chk("store_tgt", wr_tgt, 3'd0);
        chk("store_data", wr_data, 16'd0);
        tick();
        drive(1'b0, 3'd4, 3'b110, 16'hBBBB, 1'b0, 16'h0);
        chk("branch_we", we, 1'b0);
        tick();
        drive(1'b0, 3'd0, 3'b000, 16'hCCCC, 1'b0, 16'h0);
        chk("r0_we", we, 1'b0);
        tick();
        drive(1'b1, 3'd2, 3'b000, 16'hDDDD, 1'b0, 16'h0);
        chk("bubble_we", we, 1'b0);
        tick();
        chk("nowr_hv", hist_valid, 2'b01);
        chk("nowr_ht", hist_tgt, 6'd3);
        chk("nowr_hd", hist_data, 32'h0000_1234);

        // Late load to r5; later slot fields must be ignored while waiting
        drive(1'b0, 3'd5, 3'b101, 16'h0, 1'b0, 16'h0);
        chk("ll_stall1", stall_out, 1'b1);
        chk("ll_we1", we, 1'b0);
        tick();
        drive(1'b0, 3'd7, 3'b000, 16'h7777, 1'b0, 16'h0);
        chk("ll_stall2", stall_out, 1'b1);
        chk("ll_we2", we, 1'b0);
        tick();
        drive(1'b1, 3'd1, 3'b101, 16'h0, 1'b0, 16'h0);
        chk("ll_stall3", stall_out, 1'b1);
        chk("ll_we3", we, 1'b0);
        tick();
        drive(1'b0, 3'd7, 3'b000, 16'h7777, 1'b1, 16'hBEEF);
        chk("ll_we4", we, 1'b1);
        chk("ll_tgt4", wr_tgt, 3'd5);
        chk("ll_data4", wr_data, 16'hBEEF);
        chk("ll_stall4", stall_out, 1'b0);
        tick();
        chk("ll_ht", hist_tgt, 6'o35);
        chk("ll_hd", hist_data, 32'h1234_BEEF);
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b0, 16'h0);
        chk("ll_idle_stall", stall_out, 1'b0);
        chk("ll_idle_we", we, 1'b0);
        tick();

        // Halt in WAIT_MEM
        drive(1'b0, 3'd6, 3'b101, 16'h0, 1'b0, 16'h0);
        tick();
        halt = 1'b1;
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b1, 16'hCAFE);
        chk("halt_we", we, 1'b0);
        chk("halt_stall", stall_out, 1'b1);
        tick();
        chk("halt_ht", hist_tgt, 6'o35);
        chk("halt_stall2", stall_out, 1'b1);
        halt = 1'b0;
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b1, 16'hCAFE);
        chk("unhalt_we", we, 1'b1);
        chk("unhalt_tgt", wr_tgt, 3'd6);
        chk("unhalt_data", wr_data, 16'hCAFE);
        chk("unhalt_stall", stall_out, 1'b0);
        tick();
        chk("unhalt_ht", hist_tgt, 6'o56);
        chk("unhalt_hd", hist_data, 32'hBEEF_CAFE);

        // Halt in IDLE blocks an ALU write
        halt = 1'b1;
        drive(1'b0, 3'd2, 3'b000, 16'h9999, 1'b0, 16'h0);
        chk("halt_idle_we", we, 1'b0);
        tick();
        chk("halt_idle_ht", hist_tgt, 6'o56);
        halt = 1'b0;

        // History depth: r1, r2, r3
        drive(1'b0, 3'd1, 3'b000, 16'h1111, 1'b0, 16'h0);
        tick();
        drive(1'b0, 3'd2, 3'b001, 16'h2222, 1'b0, 16'h0);
        tick();
        drive(1'b0, 3'd3, 3'b111, 16'h3333, 1'b0, 16'h0);
        tick();
        chk("depth_hv", hist_valid, 2'b11);
        chk("depth_ht", hist_tgt, 6'o23);
        chk("depth_hd", hist_data, 32'h2222_3333);

        // Load with data already valid completes in the same cycle
        drive(1'b0, 3'd4, 3'b101, 16'h0, 1'b1, 16'h4444);
        chk("fastld_we", we, 1'b1);
        chk("fastld_tgt", wr_tgt, 3'd4);
        chk("fastld_data", wr_data, 16'h4444);
        chk("fastld_stall", stall_out, 1'b0);
        tick();
        chk("fastld_ht", hist_tgt, 6'o34);

        // Load to r0 never waits
        drive(1'b0, 3'd0, 3'b101, 16'h0, 1'b0, 16'h0);
        chk("ld_r0_stall", stall_out, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b0, 16'h0);
        chk("ld_r0_after", stall_out, 1'b0);
        tick();

        // Reset during WAIT_MEM abandons the load
        drive(1'b0, 3'd7, 3'b101, 16'h0, 1'b0, 16'h0);
        tick();
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b0, 16'h0);
        chk("rml_stall_pre", stall_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rml_stall", stall_out, 1'b0);
        chk("rml_hv", hist_valid, 2'b00);
        chk("rml_we", we, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 3'd0, 3'b000, 16'h0, 1'b1, 16'hF00D);
        chk("rml_post_we", we, 1'b0);
        chk("rml_post_stall", stall_out, 1'b0);
        tick();
        chk("rml_post_hv", hist_valid, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
